ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the send side of the keyboard port, alongside the existing PS/2 receive interface, and is used to send commands such as 0xED (set LEDs) and 0xFF (reset) to the keyboard. It drives the shared ps2_clock/ps2_data lines open-drain: pull low, or release. The top level resolves each pin as "oe ? 1'b0 : 1'bz".

Parameters:
INHIBIT_CYCLES, 5000, cycles the clock line is held low before the request (100 us at 50 MHz).
START_SETUP_CYCLES, 50, cycles clock and data are both held low before the clock is released.
TIMEOUT_CYCLES, 750000, maximum cycles between device clock falling edges (15 ms at 50 MHz); used only with PS2_TX_TIMEOUT_EN.

Ports:
clock  in  1  system clock; the only clock
reset  in  1  synchronous, active-high
tx_valid  in  1  command byte is offered
tx_data  in  8  command byte
tx_ready  out  1  high only in IDLE; a transfer occurs when tx_valid && tx_ready
busy  out  1  high in every state except IDLE; the receiver uses it to discard frames
ps2_clk_in  in  1  raw ps2_clock pin (asynchronous)
ps2_dat_in  in  1  raw ps2_data pin (asynchronous)
ps2_clk_oe  out  1  1 = pull ps2_clock low
ps2_dat_oe  out  1  1 = pull ps2_data low
tx_done  out  1  one-cycle pulse: frame acknowledged by the device
tx_error  out  1  one-cycle pulse: frame failed
tx_err_code  out  2  valid while tx_error is high: 01 = timeout, 10 = NACK

Behaviour:
- Reset values: all outputs are 0 except tx_ready, which is 1 (FSM in IDLE, both lines released).
- Reset mid-frame: both oe outputs drop on the next edge; FSM returns to IDLE; no done or error pulse.
- Input conditioning: ps2_clk_in and ps2_dat_in each pass through 2-FF synchronizers. A device-clock falling edge ("fall") is a one-cycle strobe when the previous synchronized clock is 1 and the current one is 0.
- Byte capture: on handshake, tx_data is latched into a shift register. Parity is odd parity, i.e. ~^tx_data. Bit counter resets to 0.
- FSM:
  - IDLE: tx_ready=1. On handshake, go to INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: clk_oe=1 and dat_oe=1 (start bit) for START_SETUP_CYCLES cycles. Then clk_oe=0 and go to SEND.
  - SEND: dat_oe remains 1 until the first fall. On fall number n (n = 1..10), the data line presents, in order: D0..D7 (LSB first), then parity, then stop. The stop bit is always 1 (released). The line is set by dat_oe = ~bit, updated in the cycle after the fall. After the 10th fall, go to ACK.
  - ACK: on the next fall, sample the synchronized data line. If it is 0, the device acknowledged: go to WAIT_IDLE. If it is 1, pulse tx_error with code 10 and go to IDLE.
  - WAIT_IDLE: wait until the synchronized clock and data are both 1. Then pulse tx_done for one cycle and go to IDLE.
- Latency: handshake to clk_oe rising is 1 cycle. The first data change follows each fall by 1 cycle (3 cycles after the pin edge, counting the synchronizer).
- tx_valid while busy: ignored, not queued.
- tx_done and tx_error are never asserted in the same cycle.
- Lines that are already low at handshake are not checked. The host always wins the inhibit.

Optional Feature:
PS2_TX_TIMEOUT_EN
- Defined: a watchdog counter runs in SEND, ACK and WAIT_IDLE. It clears on every fall and on every state entry.
- When the watchdog reaches TIMEOUT_CYCLES-1: release both lines, pulse tx_error with tx_err_code=01, and go to IDLE.
- Undefined: no counter is built. The FSM waits indefinitely for device edges, and only reset recovers it. tx_err_code 01 never occurs.

Test Plan:
- Reset check: hold reset 3 cycles -> tx_ready=1, busy=0, both oe=0, no pulses.
- Send 0xED with an ACKing device model -> bits after start are 1,0,1,1,0,1,1,1, parity 1, stop 1. Device samples each bit on its rising clock edge. Then exactly one tx_done pulse, and tx_ready returns to 1.
- Send 0x07 -> parity bit 0. Send 0xFF -> parity bit 1. Clock held low for exactly 5000 cycles, then 50 cycles with data also low.
- Device leaves data high at the 11th fall -> tx_error=1 with code 10 for one cycle; no tx_done.
- With PS2_TX_TIMEOUT_EN defined: device stops clocking after 4 bits -> tx_error with code 01 exactly 750000 cycles after the last fall, and both lines released.
- Assert reset during bit 5 of SEND -> oe outputs 0 on the next cycle, FSM in IDLE, no pulses. tx_valid pulsed while busy is ignored, and a later send of 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (keyboard command send side).
// Drives the shared ps2_clock/ps2_data lines open-drain through *_oe
// (1 = pull low, 0 = release); the top level resolves each pin as oe ? 0 : z.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   tx_valid, tx_data   command byte offer; accepted when tx_valid && tx_ready
//   tx_ready            high only while idle
//   busy                high whenever a frame is in progress
//   ps2_clk_in/dat_in   raw (asynchronous) pin levels
//   ps2_clk_oe/dat_oe   1 = pull the corresponding line low
//   tx_done             one-cycle pulse, frame acknowledged by the device
//   tx_error            one-cycle pulse, frame failed
//   tx_err_code         valid with tx_error: 01 = timeout, 10 = NACK
//
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog on device clock edges
// during SEND/ACK/WAIT_IDLE; without it the FSM waits indefinitely.

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES     = 5000,
    parameter int unsigned START_SETUP_CYCLES = 50,
    parameter int unsigned TIMEOUT_CYCLES     = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] tx_err_code
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > START_SETUP_CYCLES) ?
                                      INHIBIT_CYCLES : START_SETUP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned BIT_W   = 4;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;

    logic                 tx_ready_q, tx_ready_d;
    logic                 busy_q, busy_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 dat_oe_q, dat_oe_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [1:0]           err_code_q, err_code_d;

    // Two-stage synchronizers plus one extra clock stage for edge detection.
    logic                 clk_meta_q, clk_s_q, clk_prev_q;
    logic                 dat_meta_q, dat_s_q;
    logic                 fall_c;

    assign fall_c = clk_prev_q & ~clk_s_q;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
`else
    logic                 unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    // Frame shifts out LSB first: D0..D7, odd parity, stop.
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REQ: begin
                if (cnt_q == CNT_W'(START_SETUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (fall_c) begin
                    dat_oe_d  = ~frame_q[0];
                    frame_d   = {1'b1, frame_q[FRAME_W-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (fall_c) begin
                    if (!dat_s_q) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = ERR_NACK;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s_q && dat_s_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog: cleared by every device fall and every state change.
        wdog_d = '0;
        if (state_q == ST_SEND || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
            if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                state_d    = ST_IDLE;
                done_d     = 1'b0;
                error_d    = 1'b1;
                err_code_d = ERR_TIMEOUT;
            end else if (!fall_c && state_d == state_q) begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
`endif

        // Line drives follow the state being entered so they update with it.
        clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
        if (state_d == ST_REQ) begin
            dat_oe_d = 1'b1;
        end else if (state_d != ST_SEND) begin
            dat_oe_d = 1'b0;
        end
        tx_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State, datapath, synchronizer and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
            clk_meta_q <= 1'b1;
            clk_s_q    <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_s_q    <= 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            clk_meta_q <= ps2_clk_in;
            clk_s_q    <= clk_meta_q;
            clk_prev_q <= clk_s_q;
            dat_meta_q <= ps2_dat_in;
            dat_s_q    <= dat_meta_q;
`ifdef PS2_TX_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign tx_err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device
// model that clocks the frame, samples bits on its rising clock edge and
// optionally acknowledges. Bus lines are modelled as wired-AND with pull-ups.

module tb_ps2_host_tx;

    localparam int HALF       = 15;
    localparam int TB_TIMEOUT = 3000;

    logic       clock = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] tx_err_code;

    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    logic [1:0] last_code = 2'b00;

    always #5 clock = ~clock;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES    (5000),
        .START_SETUP_CYCLES(50),
        .TIMEOUT_CYCLES    (TB_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .tx_err_code(tx_err_code)
    );

    // Pulse counters (counted in cycles high, so a single event counts 1).
    always @(negedge clock) begin
        if (tx_done) done_cnt = done_cnt + 1;
        if (tx_error) begin
            err_cnt   = err_cnt + 1;
            last_code = tx_err_code;
        end
        if (tx_done && tx_error) both_cnt = both_cnt + 1;
    end

    task automatic start_tx(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic measure_setup(output int n_inh, output int n_set);
        n_inh = 0;
        n_set = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n_inh < 20000) begin
            n_inh++;
            @(negedge clock);
        end
        while (ps2_clk_oe && ps2_dat_oe && n_set < 20000) begin
            n_set++;
            @(negedge clock);
        end
    endtask

    // bits = {stop, parity, D7..D0, start} as seen on the data pin.
    task automatic dev_frame(input int np, input bit ack, output logic [10:0] bits);
        int k;
        bits = '0;
        k = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && k < 20000) begin
            @(negedge clock);
            k++;
        end
        repeat (10) @(negedge clock);
        bits[0] = ps2_dat_in;
        for (int p = 1; p <= np; p++) begin
            if (p == 11) begin
                dev_dat_low = ack;
                repeat (5) @(negedge clock);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
            if (p <= 10) bits[p] = ps2_dat_in;
            repeat (HALF) @(negedge clock);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int k;
        k = 0;
        while (!tx_ready && k < 500) begin
            @(negedge clock);
            k++;
        end
        ok = tx_ready;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_lines: got rdy/busy/coe/doe=%b expected 1000",
                     {tx_ready, busy, ps2_clk_oe, ps2_dat_oe});
        end
        n_cmp++;
        if ({tx_done, tx_error, tx_err_code} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses: got done/err/code=%b expected 0000",
                     {tx_done, tx_error, tx_err_code});
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
        n_cmp++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 1000",
                     {tx_ready, busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_send_ed();
        logic [10:0] bits;
        int n_inh, n_set, d0, e0;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hED);
        n_cmp++;
        if ({ps2_clk_oe, ps2_dat_oe, tx_ready, busy} !== 4'b1001) begin
            n_fail++;
            $display("FAIL ed_latency: got coe/doe/rdy/busy=%b expected 1001",
                     {ps2_clk_oe, ps2_dat_oe, tx_ready, busy});
        end
        measure_setup(n_inh, n_set);
        n_cmp++;
        if (n_inh !== 5000) begin
            n_fail++;
            $display("FAIL ed_inhibit: got %0d cycles expected 5000", n_inh);
        end
        n_cmp++;
        if (n_set !== 50) begin
            n_fail++;
            $display("FAIL ed_setup: got %0d cycles expected 50", n_set);
        end
        dev_frame(11, 1'b1, bits);
        n_cmp++;
        if (bits !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
            n_fail++;
            $display("FAIL ed_bits: got %b expected %b", bits, {1'b1, 1'b1, 8'hED, 1'b0});
        end
        wait_ready(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ed_ready: got tx_ready=0 expected 1 within 500 cycles");
        end
        n_cmp++;
        if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
            n_fail++;
            $display("FAIL ed_pulses: got done=%0d err=%0d expected done=1 err=0",
                     done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_parity();
        logic [10:0] bits;
        int n_inh, n_set, d0;
        bit ok;
        d0 = done_cnt;
        start_tx(8'h07);
        measure_setup(n_inh, n_set);
        dev_frame(11, 1'b1, bits);
        n_cmp++;
        if (bits !== {1'b1, 1'b0, 8'h07, 1'b0}) begin
            n_fail++;
            $display("FAIL p07_bits: got %b expected %b", bits, {1'b1, 1'b0, 8'h07, 1'b0});
        end
        wait_ready(ok);
        repeat (10) @(negedge clock);
        start_tx(8'hFF);
        measure_setup(n_inh, n_set);
        n_cmp++;
        if (n_inh !== 5000 || n_set !== 50) begin
            n_fail++;
            $display("FAIL ff_timing: got inhibit=%0d setup=%0d expected 5000/50", n_inh, n_set);
        end
        dev_frame(11, 1'b1, bits);
        n_cmp++;
        if (bits !== {1'b1, 1'b1, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL pff_bits: got %b expected %b", bits, {1'b1, 1'b1, 8'hFF, 1'b0});
        end
        wait_ready(ok);
        n_cmp++;
        if (!ok || (done_cnt - d0) !== 2) begin
            n_fail++;
            $display("FAIL parity_done: got ready=%0d done=%0d expected 1/2", ok, done_cnt - d0);
        end
    endtask

    task automatic test_nack();
        logic [10:0] bits;
        int n_inh, n_set, d0, e0;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h55);
        measure_setup(n_inh, n_set);
        dev_frame(11, 1'b0, bits);
        n_cmp++;
        if (bits !== {1'b1, 1'b1, 8'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL nack_bits: got %b expected %b", bits, {1'b1, 1'b1, 8'h55, 1'b0});
        end
        wait_ready(ok);
        n_cmp++;
        if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin
            n_fail++;
            $display("FAIL nack_pulses: got err=%0d done=%0d expected err=1 done=0",
                     err_cnt - e0, done_cnt - d0);
        end
        n_cmp++;
        if (last_code !== 2'b10) begin
            n_fail++;
            $display("FAIL nack_code: got %b expected 10", last_code);
        end
        n_cmp++;
        if (!ok || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL nack_idle: got ready=%0d coe=%b doe=%b expected 1/0/0",
                     ok, ps2_clk_oe, ps2_dat_oe);
        end
    endtask

    task automatic test_busy_ignore();
        logic [10:0] bits;
        int n_inh, n_set, d0;
        bit ok;
        d0 = done_cnt;
        start_tx(8'h12);
        repeat (100) @(negedge clock);
        n_cmp++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_flags: got ready=%b busy=%b expected 0/1", tx_ready, busy);
        end
        start_tx(8'h99);
        measure_setup(n_inh, n_set);
        dev_frame(11, 1'b1, bits);
        n_cmp++;
        if (bits !== {1'b1, 1'b1, 8'h12, 1'b0}) begin
            n_fail++;
            $display("FAIL busy_bits: got %b expected %b", bits, {1'b1, 1'b1, 8'h12, 1'b0});
        end
        wait_ready(ok);
        repeat (200) @(negedge clock);
        n_cmp++;
        if (!ok || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || (done_cnt - d0) !== 1) begin
            n_fail++;
            $display("FAIL busy_not_queued: got ready=%0d busy=%b coe=%b done=%0d expected 1/0/0/1",
                     ok, busy, ps2_clk_oe, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        int n_inh, n_set, d0, e0;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h33);
        measure_setup(n_inh, n_set);
        dev_frame(5, 1'b0, bits);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({ps2_clk_oe, ps2_dat_oe, tx_ready, busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL midreset_lines: got coe/doe/rdy/busy=%b expected 0010",
                     {ps2_clk_oe, ps2_dat_oe, tx_ready, busy});
        end
        reset = 1'b0;
        repeat (20) @(negedge clock);
        n_cmp++;
        if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pulses: got done=%0d err=%0d ready=%b expected 0/0/1",
                     done_cnt - d0, err_cnt - e0, tx_ready);
        end
        start_tx(8'hF4);
        measure_setup(n_inh, n_set);
        dev_frame(11, 1'b1, bits);
        n_cmp++;
        if (bits !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin
            n_fail++;
            $display("FAIL f4_bits: got %b expected %b", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        end
        wait_ready(ok);
        n_cmp++;
        if (!ok || (done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
            n_fail++;
            $display("FAIL f4_done: got ready=%0d done=%0d err=%0d expected 1/1/0",
                     ok, done_cnt - d0, err_cnt - e0);
        end
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout();
        logic [10:0] bits;
        int n_inh, n_set, d0, e0, k;
        bit seen, hit;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h05);
        measure_setup(n_inh, n_set);
        dev_frame(3, 1'b0, bits);
        // Fourth and last fall: D3=0 makes dat_oe rise one cycle after the fall.
        dev_clk_low = 1'b1;
        seen = 1'b0;
        hit = 1'b0;
        k = 0;
        for (int c = 0; c < TB_TIMEOUT + 500; c++) begin
            @(negedge clock);
            if (!seen) begin
                if (ps2_dat_oe) begin
                    seen = 1'b1;
                    k = 0;
                end
            end else begin
                k++;
                if (k == HALF) dev_clk_low = 1'b0;
                if (tx_error) begin
                    hit = 1'b1;
                    break;
                end
            end
        end
        dev_clk_low = 1'b0;
        n_cmp++;
        if (!hit || k !== TB_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_delay: got hit=%0d after %0d cycles expected %0d",
                     hit, k, TB_TIMEOUT);
        end
        n_cmp++;
        if (tx_err_code !== 2'b01 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: got code=%b coe=%b doe=%b expected 01/0/0",
                     tx_err_code, ps2_clk_oe, ps2_dat_oe);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if ((err_cnt - e0) !== 1 || (done_cnt - d0) !== 0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulses: got err=%0d done=%0d ready=%b expected 1/0/1",
                     err_cnt - e0, done_cnt - d0, tx_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_send_ed();
        test_parity();
        test_nack();
        test_busy_ignore();
        test_reset_mid_frame();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`endif
        n_cmp++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL done_and_error: got %0d overlapping cycles expected 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
